dsp_mac_sequencer: RTL and testbench

Upstream operand sequencer for the DSP48A1 slice configured with all pipeline registers enabled (A0/A1/B0/B1/M/P/OPMODE = 1, `B_INPUT="DIRECT"`). It accepts a stream of `VEC_LEN` operand pairs over a valid/ready handshake and drives the slice's A, B and OPMODE inputs so that the P register accumulates a dot product. It then captures the final P value and presents it on a valid/ready result port. CE inputs of the slice are tied high externally. The CARRYIN, D, C, BCIN and PCIN inputs are tied to 0.

---
 rtl/dsp_seq_pkg.sv | 20 ++
 rtl/flag_delay_line.sv | 29 ++
 rtl/dsp_mac_sequencer.sv | 115 +++++++++++
 tb/tb_dsp_mac_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_seq_pkg.sv
// Shared constants and types for the DSP48A1 operand sequencer.
// Default latencies follow from the slice register configuration below.
package dsp_seq_pkg;

  localparam int unsigned SLICE_A0REG = 1;
  localparam int unsigned SLICE_A1REG = 1;
  localparam int unsigned SLICE_MREG  = 1;
  localparam int unsigned SLICE_PREG  = 1;

  // Capture edge to P-update edge, inclusive of the final P load.
  localparam int unsigned DEF_PIPE_LAT = SLICE_A0REG + SLICE_A1REG + SLICE_MREG + SLICE_PREG;
  // The OPMODE register loads on the same edge the M register captures the product.
  localparam int unsigned DEF_OPMODE_DLY = SLICE_A0REG + SLICE_A1REG;

  localparam logic [7:0] OP_FIRST = 8'h01;
  localparam logic [7:0] OP_ACC   = 8'h09;

  typedef enum logic [1:0] {ACCEPT, DRAIN, HOLD} seq_state_e;

endpackage

// File: rtl/flag_delay_line.sv
// Parameterised-depth 1-bit shift register with asynchronous active-high reset.
module flag_delay_line #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] pipe_q;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk or posedge rst) begin
        if (rst) pipe_q <= '0;
        else     pipe_q <= din;
      end
    end else begin : g_multi
      always_ff @(posedge clk or posedge rst) begin
        if (rst) pipe_q <= '0;
        else     pipe_q <= {pipe_q[DEPTH-2:0], din};
      end
    end
  endgenerate

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Feeds operand pairs into a fully pipelined DSP48A1 slice so P accumulates a dot
// product, then captures P and presents it on a valid/ready result port.
module dsp_mac_sequencer #(
  parameter int unsigned VEC_LEN    = 8,
  parameter int unsigned PIPE_LAT   = dsp_seq_pkg::DEF_PIPE_LAT,
  parameter int unsigned OPMODE_DLY = dsp_seq_pkg::DEF_OPMODE_DLY,
  parameter logic [7:0]  OP_FIRST   = dsp_seq_pkg::OP_FIRST,
  parameter logic [7:0]  OP_ACC     = dsp_seq_pkg::OP_ACC
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [17:0] in_a,
  input  logic [17:0] in_b,
  output logic [17:0] dsp_a,
  output logic [17:0] dsp_b,
  output logic [7:0]  dsp_opmode,
  input  logic [47:0] dsp_p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] out_data
);
  import dsp_seq_pkg::*;

  localparam int unsigned ELEM_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int unsigned DRAIN_W = $clog2(PIPE_LAT + 1);

  localparam logic [ELEM_W-1:0]  ELEM_LAST  = ELEM_W'(VEC_LEN - 1);
  localparam logic [ELEM_W-1:0]  ELEM_ONE   = ELEM_W'(1);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(PIPE_LAT);
  localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);

  seq_state_e          state_q, state_d;
  logic [ELEM_W-1:0]   elem_cnt_q, elem_cnt_d;
  logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [47:0]         out_data_q, out_data_d;
  logic                accept;
  logic                first_flag;
  logic                first_tail;

  assign in_ready   = (state_q == ACCEPT);
  assign accept     = in_valid && in_ready;
  assign first_flag = accept && (elem_cnt_q == '0);

  // Non-accept cycles present zero operands so the slice sees M = 0 bubbles.
  assign dsp_a      = accept ? in_a : '0;
  assign dsp_b      = accept ? in_b : '0;
  assign dsp_opmode = first_tail ? OP_FIRST : OP_ACC;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;

  flag_delay_line #(
    .DEPTH(OPMODE_DLY)
  ) u_first_dly (
    .clk (CLK),
    .rst (RST),
    .din (first_flag),
    .dout(first_tail)
  );

  always_comb begin
    state_d     = state_q;
    elem_cnt_d  = elem_cnt_q;
    drain_cnt_d = drain_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    unique case (state_q)
      ACCEPT: begin
        if (accept) begin
          if (elem_cnt_q == ELEM_LAST) begin
            elem_cnt_d  = '0;
            drain_cnt_d = DRAIN_INIT;
            state_d     = DRAIN;
          end else begin
            elem_cnt_d = elem_cnt_q + ELEM_ONE;
          end
        end
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt_q - DRAIN_ONE;
        if (drain_cnt_q == DRAIN_ONE) begin
          out_data_d  = dsp_p;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCEPT;
        end
      end
      default: state_d = ACCEPT;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ACCEPT;
      elem_cnt_q  <= '0;
      drain_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      elem_cnt_q  <= elem_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench: two sequencers (VEC_LEN 4 and 1) each driving a behavioural DSP48A1 slice,
// checked every cycle against a timing/dot-product model plus literal result values.
module tb_dsp_mac_sequencer;

  localparam int unsigned PIPE_LAT = 4;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic        in_valid   [2];
  logic        in_ready   [2];
  logic [17:0] in_a       [2];
  logic [17:0] in_b       [2];
  logic [17:0] dsp_a      [2];
  logic [17:0] dsp_b      [2];
  logic [7:0]  dsp_opmode [2];
  logic [47:0] dsp_p      [2];
  logic        out_valid  [2];
  logic        out_ready  [2];
  logic [47:0] out_data   [2];

  int n_cmp = 0;
  int n_err = 0;
  logic [47:0] log0[$];
  logic [47:0] log1[$];

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  generate
    for (genvar g = 0; g < 2; g++) begin : g_lane
      localparam int unsigned VL = (g == 0) ? 4 : 1;

      dsp_mac_sequencer #(
        .VEC_LEN(VL)
      ) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid[g]),
        .in_ready  (in_ready[g]),
        .in_a      (in_a[g]),
        .in_b      (in_b[g]),
        .dsp_a     (dsp_a[g]),
        .dsp_b     (dsp_b[g]),
        .dsp_opmode(dsp_opmode[g]),
        .dsp_p     (dsp_p[g]),
        .out_valid (out_valid[g]),
        .out_ready (out_ready[g]),
        .out_data  (out_data[g])
      );

      // Behavioural slice: A0/B0, A1/B1, M, OPMODE and P registers, signed multiply.
      logic signed [17:0] a0_q, b0_q, a1_q, b1_q;
      logic signed [35:0] m_q;
      logic [7:0]         opm_q;
      logic [47:0]        p_q;

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          a0_q <= '0; b0_q <= '0; a1_q <= '0; b1_q <= '0;
          m_q <= '0; opm_q <= '0; p_q <= '0;
        end else begin
          a0_q  <= dsp_a[g];
          b0_q  <= dsp_b[g];
          a1_q  <= a0_q;
          b1_q  <= b0_q;
          m_q   <= a1_q * b1_q;
          opm_q <= dsp_opmode[g];
          p_q   <= ((opm_q[3:2] == 2'b10) ? p_q : 48'd0) +
                   ((opm_q[1:0] == 2'b01) ? {{12{m_q[35]}}, m_q} : 48'd0);
        end
      end
      assign dsp_p[g] = p_q;

      // Reference model: accepted pairs, dot-product sum, result due PIPE_LAT edges later.
      int          cnt = 0;
      int          cyc = 0;
      int          due = 0;
      bit          draining = 1'b0;
      bit          holding = 1'b0;
      bit          f0 = 1'b0;
      bit          f1 = 1'b0;
      longint      sum = 0;
      logic [47:0] hold_data = '0;

      always @(posedge CLK) begin
        bit rdy, acc;
        if (RST) begin
          cnt = 0; draining = 1'b0; holding = 1'b0; f0 = 1'b0; f1 = 1'b0; sum = 0;
        end else begin
          cyc++;
          rdy = !draining && !holding;
          acc = in_valid[g] && rdy;
          f1 = f0;
          f0 = acc && (cnt == 0);
          if (holding && out_ready[g]) holding = 1'b0;
          if (draining && cyc == due) begin
            draining  = 1'b0;
            holding   = 1'b1;
            hold_data = sum[47:0];
          end
          if (acc) begin
            if (cnt == 0) sum = 0;
            sum += longint'($signed(in_a[g])) * longint'($signed(in_b[g]));
            cnt++;
            if (cnt == int'(VL)) begin
              cnt      = 0;
              draining = 1'b1;
              due      = cyc + int'(PIPE_LAT);
            end
          end
        end
      end

      always @(negedge CLK) begin
        bit rdy, acc;
        if (RST) begin
          chk($sformatf("lane%0d out_valid in reset", g), 48'(out_valid[g]), 48'd0);
          chk($sformatf("lane%0d opmode in reset", g), 48'(dsp_opmode[g]), 48'h09);
        end else begin
          rdy = !draining && !holding;
          acc = in_valid[g] && rdy;
          chk($sformatf("lane%0d in_ready", g), 48'(in_ready[g]), 48'(rdy));
          chk($sformatf("lane%0d out_valid", g), 48'(out_valid[g]), 48'(holding));
          if (holding) chk($sformatf("lane%0d out_data", g), out_data[g], hold_data);
          chk($sformatf("lane%0d dsp_a", g), 48'(dsp_a[g]), acc ? 48'(in_a[g]) : 48'd0);
          chk($sformatf("lane%0d dsp_b", g), 48'(dsp_b[g]), acc ? 48'(in_b[g]) : 48'd0);
          chk($sformatf("lane%0d dsp_opmode", g), 48'(dsp_opmode[g]), f1 ? 48'h01 : 48'h09);
          if (out_valid[g] && out_ready[g]) begin
            if (g == 0) log0.push_back(out_data[g]);
            else        log1.push_back(out_data[g]);
          end
        end
      end
    end
  endgenerate

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input int g, input logic [17:0] a, input logic [17:0] b);
    bit rdy = 1'b0;
    bit done = 1'b0;
    in_valid[g] = 1'b1;
    in_a[g] = a;
    in_b[g] = b;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge CLK);
      rdy = in_ready[g];
      tick();
      done = rdy;
    end
    chk($sformatf("lane%0d send accepted", g), 48'(done), 48'd1);
    in_valid[g] = 1'b0;
    in_a[g] = '0;
    in_b[g] = '0;
  endtask

  task automatic wait_out(input int g, input bit need_ready);
    bit done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge CLK);
      done = out_valid[g] && (!need_ready || out_ready[g]);
      tick();
    end
    chk($sformatf("lane%0d result seen", g), 48'(done), 48'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] exp0 [7];
    exp0 = '{48'd100, 48'd100, 48'd4, 48'd24, 48'd4, 48'd84, 48'd16};
    RST = 1'b1;
    for (int g = 0; g < 2; g++) begin
      in_valid[g] = 1'b0; in_a[g] = '0; in_b[g] = '0; out_ready[g] = 1'b1;
    end
    repeat (3) tick();
    RST = 1'b0;
    chk("lane0 out_data after reset", out_data[0], 48'd0);
    chk("lane1 out_data after reset", out_data[1], 48'd0);
    chk("lane0 in_ready after reset", 48'(in_ready[0]), 48'd1);

    // Dense stream.
    send(0, 18'd1, 18'd2); send(0, 18'd3, 18'd4); send(0, 18'd5, 18'd6); send(0, 18'd7, 18'd8);
    wait_out(0, 1'b1);

    // Same pairs with two bubble cycles between them.
    send(0, 18'd1, 18'd2); repeat (2) tick();
    send(0, 18'd3, 18'd4); repeat (2) tick();
    send(0, 18'd5, 18'd6); repeat (2) tick();
    send(0, 18'd7, 18'd8);
    wait_out(0, 1'b1);

    // Back-to-back vectors.
    for (int i = 0; i < 4; i++) send(0, 18'd1, 18'd1);
    for (int i = 0; i < 4; i++) send(0, 18'd2, 18'd3);
    wait_out(0, 1'b1);

    // Consumer stalls in HOLD while an operand is offered.
    out_ready[0] = 1'b0;
    for (int i = 0; i < 4; i++) send(0, 18'd1, 18'd1);
    wait_out(0, 1'b0);
    in_valid[0] = 1'b1; in_a[0] = 18'd9; in_b[0] = 18'd9;
    repeat (5) tick();
    out_ready[0] = 1'b1;
    send(0, 18'd9, 18'd9);
    for (int i = 0; i < 3; i++) send(0, 18'd1, 18'd1);
    wait_out(0, 1'b1);

    // Single-element vector, signed operands.
    send(1, -18'sd3, 18'sd5);
    wait_out(1, 1'b1);

    // Reset mid-vector, then a full vector.
    send(0, 18'd5, 18'd5); send(0, 18'd5, 18'd5);
    RST = 1'b1;
    repeat (2) tick();
    RST = 1'b0;
    for (int i = 0; i < 4; i++) send(0, 18'd2, 18'd2);
    wait_out(0, 1'b1);
    repeat (3) tick();

    chk("lane0 result count", 48'(log0.size()), 48'd7);
    for (int i = 0; i < 7; i++)
      if (i < log0.size()) chk($sformatf("lane0 result %0d", i), log0[i], exp0[i]);
    chk("lane1 result count", 48'(log1.size()), 48'd1);
    if (log1.size() > 0) chk("lane1 result -15", log1[0], 48'hFFFF_FFFF_FFF1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
